uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter among NUM_REQ requesters using round-robin arbitration.

---
 rtl/uart_tx_scheduler.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ requesters.
// It latches the winner's byte, holds tx_start until tx_busy, waits for a tx_done rising
// edge, then pulses ack. A watchdog aborts a frame that never completes.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         err,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic                         tx_start,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_busy,
  input  logic                         tx_done
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam int unsigned SEL_W = $clog2(NUM_REQ * DATA_W);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic                active_q, active_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                done_q;

  logic                win_valid_c;
  logic [ID_W-1:0]     win_id_c;
  logic [DATA_W-1:0]   win_data_c;
  logic [ID_W-1:0]     nxt_ptr_c;
  logic                timeout_c;
  logic                done_rise_c;

  // Round-robin search: first set req bit from ptr upward, wrapping at NUM_REQ.
  always_comb begin : arb
    int unsigned idx;
    idx         = 0;
    win_valid_c = 1'b0;
    win_id_c    = '0;
    win_data_c  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_valid_c && req[ID_W'(idx)]) begin
        win_valid_c = 1'b1;
        win_id_c    = ID_W'(idx);
        win_data_c  = req_data[SEL_W'(idx * DATA_W) +: DATA_W];
      end
    end
  end

  // Pointer successor of the current owner, watchdog expiry and fresh end-of-frame edge.
  always_comb begin
    nxt_ptr_c   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
    timeout_c   = (timer_q == TMR_W'(TIMEOUT - 1));
    done_rise_c = tx_done & ~done_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    err_d    = 1'b0;
    grant_d  = grant_q;
    active_d = active_q;
    start_d  = start_q;
    data_d   = data_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE: begin
        if (win_valid_c) begin
          grant_d  = win_id_c;
          data_d   = win_data_c;
          start_d  = 1'b1;
          active_d = 1'b1;
          timer_d  = '0;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = timer_q + TMR_W'(1);
        if (tx_busy) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (timeout_c) begin
          err_d    = 1'b1;
          start_d  = 1'b0;
          active_d = 1'b0;
          ptr_d    = nxt_ptr_c;
          state_d  = IDLE;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_q + TMR_W'(1);
        if (done_rise_c) begin
          ack_d[grant_q] = 1'b1;
          state_d        = RELEASE;
        end else if (timeout_c) begin
          err_d    = 1'b1;
          start_d  = 1'b0;
          active_d = 1'b0;
          ptr_d    = nxt_ptr_c;
          state_d  = IDLE;
        end
      end
      RELEASE: begin
        active_d = 1'b0;
        ptr_d    = nxt_ptr_c;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      grant_q  <= '0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
      timer_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      start_q  <= start_d;
      data_q   <= data_d;
      timer_q  <= timer_d;
      done_q   <= tx_done;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign grant_id = grant_q;
  assign active   = active_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected owners/bytes are queued when requests
// are driven and compared when the scheduler grants and acknowledges.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] bytes [4];
  logic [31:0] req_data;
  logic [3:0] ack;
  logic       err;
  logic [1:0] grant_id;
  logic       active;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  // Short-watchdog instance
  logic [3:0] req_t;
  logic [31:0] data_t;
  logic [3:0] ack_t;
  logic       err_t;
  logic [1:0] gid_t;
  logic       active_t;
  logic       start_t;
  logic [7:0] txd_t;
  logic       busy_t;
  logic       done_t;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   sb_to[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  assign req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
  assign data_t   = 32'h4433_2211;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .grant_id(grant_id), .active(active), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(64)) dut_to (
    .clk(clk), .rst(rst), .req(req_t), .req_data(data_t), .ack(ack_t), .err(err_t),
    .grant_id(gid_t), .active(active_t), .tx_start(start_t), .tx_data(txd_t),
    .tx_busy(busy_t), .tx_done(done_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id   = id;
    e.data = bytes[id];
    sb.push_back(e);
  endtask

  // Wait for a grant, play a transmitter (busy 2 cycles after start, done after done_dly),
  // and compare the grant and ack against the scoreboard head.
  task automatic serve(input int done_dly, input bit drop, input bit stale);
    exp_t e;
    int   t;
    t = 0;
    while (!active && t < 20) begin
      step();
      t++;
    end
    check("grant_active", 32'(active), 32'(1));
    check("grant_lat", 32'(t), 32'(1));
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'(1));
      return;
    end
    e = sb.pop_front();
    check("grant_id", 32'(grant_id), 32'(e.id));
    check("tx_data", 32'(tx_data), 32'(e.data));
    check("tx_start", 32'(tx_start), 32'(1));
    if (drop) begin
      req         = '0;
      bytes[e.id] = ~bytes[e.id];
    end
    step();
    step();
    check("start_held", 32'(tx_start), 32'(1));
    tx_busy = 1'b1;
    step();
    check("start_drop", 32'(tx_start), 32'(0));
    repeat (done_dly) step();
    check("pre_done_ack", 32'(ack), 32'(0));
    check("pre_done_active", 32'(active), 32'(1));
    if (stale) begin
      tx_done = 1'b0;
      step();
      check("stale_no_ack", 32'(ack), 32'(0));
    end
    tx_done = 1'b1;
    tx_busy = 1'b0;
    step();
    check("ack", 32'(ack), 32'(1) << e.id);
    check("ack_err", 32'(err), 32'(0));
    check("tx_data_hold", 32'(tx_data), 32'(e.data));
    step();
    check("ack_pulse", 32'(ack), 32'(0));
    check("release_active", 32'(active), 32'(0));
    tx_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst     = 1'b0;
    req     = '0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    req_t   = '0;
    busy_t  = 1'b0;
    done_t  = 1'b0;
    for (int i = 0; i < 4; i++) bytes[i] = 8'h00;
    step();
    step();
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_active", 32'(active), 32'(0));
    check("rst_tx_start", 32'(tx_start), 32'(0));
    check("rst_grant_id", 32'(grant_id), 32'(0));
    rst = 1'b1;
    step();

    // T2: all four requesting, rotation 0,1,2,3,0
    for (int i = 0; i < 4; i++) bytes[i] = 8'h10 + 8'(i);
    req = 4'b1111;
    push(0); push(1); push(2); push(3); push(0);
    for (int k = 0; k < 5; k++) serve(4, 1'b0, 1'b0);
    req = '0;
    repeat (3) step();
    check("idle_grant_hold", 32'(grant_id), 32'(0));

    // T1: single requester, long frame, req dropped and data changed after grant
    bytes[0] = 8'hA5;
    req = 4'b0001;
    push(0);
    serve(1040, 1'b1, 1'b0);

    // T3: serve 1 so ptr=2, then 0 beats 1 on wrap search
    bytes[1] = 8'h3C;
    req = 4'b0010;
    push(1);
    serve(4, 1'b0, 1'b0);
    req = '0;
    bytes[0] = 8'h55;
    req = 4'b0011;
    push(0);
    push(1);
    serve(4, 1'b0, 1'b0);
    req = 4'b0010;
    serve(4, 1'b0, 1'b0);
    req = '0;

    // T5: tx_done stuck high before grant must be ignored
    tx_done = 1'b1;
    repeat (3) step();
    bytes[3] = 8'hC3;
    req = 4'b1000;
    push(3);
    serve(6, 1'b0, 1'b1);
    req = '0;

    // T6: reset while waiting for done
    bytes[1] = 8'h99;
    req = 4'b0010;
    t = 0;
    while (!active && t < 20) begin
      step();
      t++;
    end
    check("t6_grant", 32'(grant_id), 32'(1));
    step();
    step();
    tx_busy = 1'b1;
    step();
    step();
    check("t6_wait_active", 32'(active), 32'(1));
    rst = 1'b0;
    #2;
    check("t6_ack", 32'(ack), 32'(0));
    check("t6_err", 32'(err), 32'(0));
    check("t6_grant_id", 32'(grant_id), 32'(0));
    check("t6_active", 32'(active), 32'(0));
    check("t6_tx_start", 32'(tx_start), 32'(0));
    check("t6_tx_data", 32'(tx_data), 32'(0));
    tx_busy = 1'b0;
    req = '0;
    step();
    rst = 1'b1;
    step();
    bytes[2] = 8'h77;
    req = 4'b0100;
    push(2);
    serve(4, 1'b0, 1'b0);
    req = '0;

    // T4: TIMEOUT=64 instance, transmitter never busy
    req_t = 4'b0011;
    sb_to.push_back(0);
    sb_to.push_back(1);
    t = 0;
    while (!active_t && t < 20) begin
      step();
      t++;
    end
    check("t4_grant_active", 32'(active_t), 32'(1));
    check("t4_grant_id", 32'(gid_t), 32'(sb_to.pop_front()));
    repeat (63) step();
    check("t4_err_early", 32'(err_t), 32'(0));
    check("t4_start_held", 32'(start_t), 32'(1));
    step();
    check("t4_err", 32'(err_t), 32'(1));
    check("t4_start_fall", 32'(start_t), 32'(0));
    check("t4_active_fall", 32'(active_t), 32'(0));
    check("t4_no_ack", 32'(ack_t), 32'(0));
    req_t = 4'b0010;
    step();
    check("t4_err_pulse", 32'(err_t), 32'(0));
    check("t4_next_active", 32'(active_t), 32'(1));
    check("t4_next_id", 32'(gid_t), 32'(sb_to.pop_front()));
    check("t4_next_data", 32'(txd_t), 32'(8'h22));
    busy_t = 1'b1;
    step();
    done_t = 1'b1;
    busy_t = 1'b0;
    step();
    check("t4_ack", 32'(ack_t), 32'(4'b0010));
    check("t4_ack_err", 32'(err_t), 32'(0));
    req_t  = '0;
    done_t = 1'b0;
    step();
    check("t4_release", 32'(active_t), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
